// File: rtl/vpu_vcfg_unit.sv
// Vector configuration unit: executes vsetvli/vsetivli/vsetvl and vector CSR reads,
// holds architectural vl/vtype and hands scalar results to commit via valid/commit.
module vpu_vcfg_unit #(
    parameter int VLEN = 128,
    parameter int ELEN = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [1:0]  cfg_op_i,
    input  logic        rs1_zero_i,
    input  logic        rd_zero_i,
    input  logic [31:0] avl_i,
    input  logic [31:0] vtype_i,
    input  logic [1:0]  csr_sel_i,
    input  logic        flush_i,
    output logic        VCFG_read_valid_o,
    output logic [31:0] VCFG_read_data_o,
    input  logic        VCFG_commit_i,
    output logic [31:0] vl_o,
    output logic [31:0] vtype_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_e;
    typedef enum logic [1:0] {OP_VSETVLI, OP_VSETIVLI, OP_VSETVL, OP_CSR} op_e;

    localparam int          MAX_VSEW  = $clog2(ELEN / 8);
    localparam logic [31:0] VLENB     = 32'(VLEN / 8);
    localparam logic [31:0] VTYPE_ILL = 32'h8000_0000;

    state_e      state_q, state_d;
    op_e         op_q;
    logic        rs1_zero_q, rd_zero_q;
    logic [31:0] avl_q, req_vtype_q;
    logic [1:0]  csr_sel_q;
    logic        valid_q, upd_q;
    logic [31:0] data_q, new_vl_q, new_vtype_q;
    logic [31:0] vl_q, vtype_q;
    logic        accept;

    assign accept = (state_q == S_IDLE) && cfg_valid_i && !flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_CALC;
            S_CALC:  state_d = flush_i ? S_IDLE : S_RESP;
            S_RESP:  if (flush_i || VCFG_commit_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: operand registers are reset too, so nothing downstream ever sees X after reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q        <= OP_VSETVLI;
            rs1_zero_q  <= 1'b0;
            rd_zero_q   <= 1'b0;
            avl_q       <= '0;
            req_vtype_q <= '0;
            csr_sel_q   <= '0;
        end else if (accept) begin
            op_q        <= op_e'(cfg_op_i);
            rs1_zero_q  <= rs1_zero_i;
            rd_zero_q   <= rd_zero_i;
            avl_q       <= avl_i;
            req_vtype_q <= vtype_i;
            csr_sel_q   <= csr_sel_i;
        end
    end

    logic [2:0]  vlmul, vsew;
    logic        frac;
    logic [1:0]  frac_k;
    logic        illegal;
    logic [31:0] vlen_per_sew, vlmax, avl_eff, new_vl_c, csr_data;

    always_comb begin
        vlmul  = req_vtype_q[2:0];
        vsew   = req_vtype_q[5:3];
        frac   = vlmul[2];
        frac_k = 2'(4'd8 - {1'b0, vlmul});
        // Fractional LMUL is legal only while SEW <= ELEN*LMUL, i.e. vsew + k <= log2(ELEN/8).
        illegal = (|req_vtype_q[31:8]) || (int'(vsew) > MAX_VSEW) || (vlmul == 3'd4)
                  || (frac && (int'(vsew) + int'(frac_k) > MAX_VSEW));
        vlen_per_sew = 32'(VLEN) >> ({1'b0, vsew} + 4'd3);
        vlmax        = frac ? (vlen_per_sew >> frac_k) : (vlen_per_sew << vlmul[1:0]);

        avl_eff = avl_q;
        if (op_q != OP_VSETIVLI && rs1_zero_q) avl_eff = rd_zero_q ? vl_q : vlmax;
        new_vl_c = (avl_eff <= vlmax) ? avl_eff : vlmax;

        unique case (csr_sel_q)
            2'd0:    csr_data = vl_q;
            2'd1:    csr_data = vtype_q;
            2'd2:    csr_data = VLENB;
            default: csr_data = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q     <= 1'b0;
            data_q      <= '0;
            upd_q       <= 1'b0;
            new_vl_q    <= '0;
            new_vtype_q <= VTYPE_ILL;
        end else if (state_q == S_CALC && !flush_i) begin
            valid_q <= 1'b1;
            if (op_q == OP_CSR) begin
                data_q <= csr_data;
                upd_q  <= 1'b0;
            end else if (illegal) begin
                data_q      <= '0;
                upd_q       <= 1'b1;
                new_vl_q    <= '0;
                new_vtype_q <= VTYPE_ILL;
            end else begin
                data_q      <= new_vl_c;
                upd_q       <= 1'b1;
                new_vl_q    <= new_vl_c;
                new_vtype_q <= req_vtype_q;
            end
        end else if (state_q == S_RESP && (flush_i || VCFG_commit_i)) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end
    end

    // Architectural CSRs change only when commit accepts an un-flushed config result.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vl_q    <= '0;
            vtype_q <= VTYPE_ILL;
        end else if (state_q == S_RESP && VCFG_commit_i && !flush_i && upd_q) begin
            vl_q    <= new_vl_q;
            vtype_q <= new_vtype_q;
        end
    end

    assign cfg_ready_o       = (state_q == S_IDLE);
    assign VCFG_read_valid_o = valid_q;
    assign VCFG_read_data_o  = data_q;
    assign vl_o              = vl_q;
    assign vtype_o           = vtype_q;

endmodule

// File: tb/tb_vpu_vcfg_unit.sv
// Self-checking bench for vpu_vcfg_unit: directed scenarios plus randomized ops
// compared against an arithmetic model of vl/vtype semantics.
module tb_vpu_vcfg_unit;

    localparam int VLEN = 128;
    localparam int ELEN = 32;
    localparam logic [31:0] ILL = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cfg_valid_i, cfg_ready_o;
    logic [1:0]  cfg_op_i;
    logic        rs1_zero_i, rd_zero_i;
    logic [31:0] avl_i, vtype_i;
    logic [1:0]  csr_sel_i;
    logic        flush_i;
    logic        VCFG_read_valid_o;
    logic [31:0] VCFG_read_data_o;
    logic        VCFG_commit_i;
    logic [31:0] vl_o, vtype_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_vl    = 32'd0;
    logic [31:0] m_vtype = ILL;

    vpu_vcfg_unit #(.VLEN(VLEN), .ELEN(ELEN)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_op_i(cfg_op_i), .rs1_zero_i(rs1_zero_i), .rd_zero_i(rd_zero_i),
        .avl_i(avl_i), .vtype_i(vtype_i), .csr_sel_i(csr_sel_i),
        .flush_i(flush_i),
        .VCFG_read_valid_o(VCFG_read_valid_o), .VCFG_read_data_o(VCFG_read_data_o),
        .VCFG_commit_i(VCFG_commit_i),
        .vl_o(vl_o), .vtype_o(vtype_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Model: SEW in bits, LMUL as num/den, VLMAX = VLEN*LMUL/SEW.
    task automatic ref_exec(input logic [1:0] op, input logic rs1z, input logic rdz,
                            input logic [31:0] avl, input logic [31:0] vt, input logic [1:0] csel,
                            output logic [31:0] data, output logic [31:0] nvl,
                            output logic [31:0] nvt, output bit upd);
        longint sew, num, den, vlmax, a;
        int lm;
        bit bad;
        nvl = m_vl;
        nvt = m_vtype;
        if (op == 2'd3) begin
            upd = 0;
            case (csel)
                2'd0: data = m_vl;
                2'd1: data = m_vtype;
                2'd2: data = VLEN / 8;
                default: data = 32'd0;
            endcase
            return;
        end
        upd = 1;
        sew = 64'd8 << vt[5:3];
        lm  = int'(vt[2:0]);
        num = 1; den = 1;
        if (lm < 4) num = 64'd1 << lm;
        else if (lm > 4) den = 64'd1 << (8 - lm);
        bad = (vt[31:8] != 0) || (sew > ELEN) || (lm == 4) || (den > 1 && sew * den > ELEN);
        if (bad) begin
            data = 0; nvl = 0; nvt = ILL;
            return;
        end
        vlmax = (VLEN * num) / (sew * den);
        if (op != 2'd1 && rs1z) a = rdz ? longint'(m_vl) : vlmax;
        else a = longint'(avl);
        nvl  = 32'((a <= vlmax) ? a : vlmax);
        data = nvl;
        nvt  = vt;
    endtask

    task automatic idle_inputs();
        cfg_valid_i = 0; cfg_op_i = 0; rs1_zero_i = 0; rd_zero_i = 0;
        avl_i = 0; vtype_i = 0; csr_sel_i = 0; flush_i = 0; VCFG_commit_i = 0;
    endtask

    // Issues one op from IDLE, holds RESP for 'hold' cycles, then commits if asked.
    task automatic exec_op(input string name, input logic [1:0] op, input logic rs1z, input logic rdz,
                           input logic [31:0] avl, input logic [31:0] vt, input logic [1:0] csel,
                           input int hold, input bit do_commit);
        logic [31:0] e_data, e_vl, e_vt;
        bit upd;
        ref_exec(op, rs1z, rdz, avl, vt, csel, e_data, e_vl, e_vt, upd);
        n_checks++;
        if (cfg_ready_o !== 1'b1) $display("FAIL %s ready_before_accept: got %b want 1", name, cfg_ready_o);
        else n_pass++;
        cfg_valid_i = 1; cfg_op_i = op; rs1_zero_i = rs1z; rd_zero_i = rdz;
        avl_i = avl; vtype_i = vt; csr_sel_i = csel;
        tick();
        cfg_valid_i = 0; avl_i = $urandom; vtype_i = $urandom; cfg_op_i = 2'($urandom);
        rs1_zero_i = 1'($urandom); rd_zero_i = 1'($urandom); csr_sel_i = 2'($urandom);
        n_checks++;
        if (cfg_ready_o !== 1'b0 || VCFG_read_valid_o !== 1'b0)
            $display("FAIL %s calc_state: ready=%b valid=%b want 0/0", name, cfg_ready_o, VCFG_read_valid_o);
        else n_pass++;
        tick();
        for (int i = 0; i <= hold; i++) begin
            n_checks++;
            if (VCFG_read_valid_o !== 1'b1 || VCFG_read_data_o !== e_data || cfg_ready_o !== 1'b0
                || vl_o !== m_vl || vtype_o !== m_vtype)
                $display("FAIL %s resp[%0d]: valid=%b data=%h ready=%b vl=%h vtype=%h want 1 %h 0 %h %h",
                         name, i, VCFG_read_valid_o, VCFG_read_data_o, cfg_ready_o, vl_o, vtype_o,
                         e_data, m_vl, m_vtype);
            else n_pass++;
            if (i < hold) tick();
        end
        if (do_commit) begin
            VCFG_commit_i = 1;
            tick();
            VCFG_commit_i = 0;
            if (upd) begin m_vl = e_vl; m_vtype = e_vt; end
            n_checks++;
            if (VCFG_read_valid_o !== 1'b0 || cfg_ready_o !== 1'b1 || vl_o !== m_vl || vtype_o !== m_vtype)
                $display("FAIL %s after_commit: valid=%b ready=%b vl=%h vtype=%h want 0 1 %h %h",
                         name, VCFG_read_valid_o, cfg_ready_o, vl_o, vtype_o, m_vl, m_vtype);
            else n_pass++;
        end
    endtask

    task automatic check_arch(input string name);
        n_checks++;
        if (vl_o !== m_vl || vtype_o !== m_vtype || VCFG_read_valid_o !== 1'b0 || cfg_ready_o !== 1'b1)
            $display("FAIL %s: vl=%h vtype=%h valid=%b ready=%b want %h %h 0 1",
                     name, vl_o, vtype_o, VCFG_read_valid_o, cfg_ready_o, m_vl, m_vtype);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_checks++;
        if (vl_o !== 32'd0 || vtype_o !== ILL || cfg_ready_o !== 1'b1
            || VCFG_read_valid_o !== 1'b0 || VCFG_read_data_o !== 32'd0)
            $display("FAIL reset_values: vl=%h vtype=%h ready=%b valid=%b data=%h want 0 80000000 1 0 0",
                     vl_o, vtype_o, cfg_ready_o, VCFG_read_valid_o, VCFG_read_data_o);
        else n_pass++;
    endtask

    task automatic test_directed();
        exec_op("vsetvli_e32m1", 2'd0, 0, 0, 32'd10, 32'h10, 0, 0, 1);
        exec_op("vsetvli_vlmax_e16m2", 2'd0, 1, 0, 32'd0, 32'h09, 0, 0, 1);
        exec_op("vsetivli_e8m8", 2'd1, 0, 0, 32'd100, 32'h03, 0, 0, 1);
        exec_op("vsetvl_keep_vl", 2'd2, 1, 1, 32'd7, 32'h08, 0, 0, 1);
        exec_op("vsetvl_mf8_illegal", 2'd2, 0, 0, 32'd5, 32'h15, 0, 0, 1);
        exec_op("csr_vlenb", 2'd3, 0, 0, 32'd0, 32'd0, 2'd2, 0, 1);
        exec_op("vsetvli_mf4_e8", 2'd0, 0, 0, 32'hFFFF_FFFF, 32'hC6, 0, 0, 1);
        exec_op("csr_vl", 2'd3, 0, 0, 32'd0, 32'd0, 2'd0, 0, 1);
        exec_op("csr_vtype", 2'd3, 0, 0, 32'd0, 32'd0, 2'd1, 0, 1);
        exec_op("csr_reserved", 2'd3, 0, 0, 32'd0, 32'd0, 2'd3, 0, 1);
        exec_op("vsetvli_vlmul4", 2'd0, 0, 0, 32'd3, 32'h04, 0, 0, 1);
        exec_op("vsetvli_high_bits", 2'd0, 0, 0, 32'd3, 32'h0000_0110, 0, 0, 1);
    endtask

    task automatic test_hold_commit();
        exec_op("hold3_e16m1", 2'd0, 0, 1, 32'd5, 32'h08, 0, 3, 1);
        exec_op("back_to_back", 2'd1, 0, 0, 32'd31, 32'h07, 0, 0, 1);
    endtask

    task automatic test_flush_calc();
        cfg_valid_i = 1; cfg_op_i = 0; avl_i = 32'd2; vtype_i = 32'h00;
        tick();
        cfg_valid_i = 0; flush_i = 1;
        tick();
        flush_i = 0;
        check_arch("flush_calc_idle");
        tick();
        check_arch("flush_calc_no_valid");
    endtask

    task automatic test_flush_commit();
        cfg_valid_i = 1; cfg_op_i = 0; avl_i = 32'd1; vtype_i = 32'h00;
        tick();
        cfg_valid_i = 0;
        tick();
        flush_i = 1; VCFG_commit_i = 1;
        tick();
        flush_i = 0; VCFG_commit_i = 0;
        check_arch("flush_with_commit");
    endtask

    task automatic test_flush_idle();
        cfg_valid_i = 1; flush_i = 1; VCFG_commit_i = 1; cfg_op_i = 0; avl_i = 32'd3; vtype_i = 32'h00;
        tick();
        cfg_valid_i = 0; flush_i = 0; VCFG_commit_i = 0;
        check_arch("flush_blocks_accept");
        tick();
        check_arch("flush_idle_no_valid");
    endtask

    task automatic test_reset_mid();
        cfg_valid_i = 1; cfg_op_i = 1; avl_i = 32'd9; vtype_i = 32'h00;
        tick();
        cfg_valid_i = 0;
        tick();
        #2 rst_i = 0;
        #1;
        m_vl = 0; m_vtype = ILL;
        n_checks++;
        if (VCFG_read_valid_o !== 1'b0 || VCFG_read_data_o !== 32'd0 || cfg_ready_o !== 1'b1
            || vl_o !== 32'd0 || vtype_o !== ILL)
            $display("FAIL reset_mid_resp: valid=%b data=%h ready=%b vl=%h vtype=%h want 0 0 1 0 80000000",
                     VCFG_read_valid_o, VCFG_read_data_o, cfg_ready_o, vl_o, vtype_o);
        else n_pass++;
        tick();
        rst_i = 1;
        tick();
        check_arch("after_reset_release");
    endtask

    task automatic test_random();
        logic [31:0] vt, avl;
        for (int n = 0; n < 250; n++) begin
            vt = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) vt[8 + $urandom_range(0, 23)] = 1'b1;
            case ($urandom_range(0, 3))
                0: avl = 32'($urandom_range(0, 20));
                1: avl = 32'($urandom_range(0, 300));
                2: avl = $urandom;
                default: avl = 32'hFFFF_FFFF;
            endcase
            exec_op("random", 2'($urandom), 1'($urandom), 1'($urandom), avl, vt,
                    2'($urandom), $urandom_range(0, 2), 1);
        end
    endtask

    initial begin
        idle_inputs();
        rst_i = 0;
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1;
        tick();
        test_reset();
        test_directed();
        test_hold_commit();
        test_flush_calc();
        test_flush_commit();
        test_flush_idle();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vpu_vcfg_unit.md
# vpu_vcfg_unit

Vector configuration unit of the VPU. It executes vsetvli, vsetivli and vsetvl, and vector CSR reads (vl, vtype, vlenb) issued by the VPU decoder. It holds the architectural vl and vtype registers and broadcasts them to the execute stage. Scalar results go to the commit stage through a valid/commit handshake, and CSR state updates only when the commit stage accepts the result.

## Interface
Parameters:
- VLEN, 128: vector register length in bits, power of two, 64..1024.
- ELEN, 32: maximum element width in bits; SEW 8/16/32 supported.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_i  input  1  reset, asynchronous, active-low (asserted when 0).
- cfg_valid_i  input  1  decoder presents a config/CSR op.
- cfg_ready_o  output  1  unit can accept an op; high only in IDLE.
- cfg_op_i  input  2  0=vsetvli, 1=vsetivli, 2=vsetvl, 3=csr read.
- rs1_zero_i  input  1  rs1 field is x0 (vsetvli/vsetvl only).
- rd_zero_i  input  1  rd field is x0.
- avl_i  input  32  AVL: rs1 value, or zero-extended uimm for vsetivli.
- vtype_i  input  32  requested vtype: zero-extended zimm, or rs2 value for vsetvl.
- csr_sel_i  input  2  csr read select: 0=vl, 1=vtype, 2=vlenb, 3=reserved (reads 0).
- flush_i  input  1  pipeline flush; aborts the pending op.
- VCFG_read_valid_o  output  1  scalar result available to commit stage.
- VCFG_read_data_o  output  32  scalar result (new vl, or CSR value).
- VCFG_commit_i  input  1  commit stage accepts the result.
- vl_o  output  32  architectural vl to EXE.
- vtype_o  output  32  architectural vtype to EXE.

## Operation
- FSM states are IDLE, CALC and RESP.
  - IDLE -> CALC when cfg_valid_i && cfg_ready_o; operands are latched.
  - CALC -> RESP unconditionally.
  - RESP -> IDLE on VCFG_commit_i.
  - flush_i in CALC or RESP -> IDLE, with no CSR update and no valid.
  - flush_i in IDLE is ignored, but it blocks acceptance that cycle.
- vtype decode: vlmul=[2:0], vsew=[5:3], vta=[6], vma=[7], vill=[31].
  - SEW = 8<<vsew.
  - LMUL codes: m1..m8 = 0..3, mf8=5, mf4=6, mf2=7.
- Illegal vtype when any of the following holds:
  - bits [31:8] nonzero;
  - vsew > log2(ELEN/8);
  - vlmul == 4;
  - fractional LMUL with SEW > ELEN*LMUL (ELEN=32: mf8 always illegal, mf4 only e8, mf2 e8/e16).
- Illegal vtype result: new vtype = 0x8000_0000, new vl = 0, result = 0.
- VLMAX = (VLEN/SEW)*LMUL for integer LMUL, (VLEN/SEW)>>k for mf(2^k); computed in CALC as a registered value.
- AVL selection:
  - vsetivli: avl_i.
  - rs1_zero_i=0: avl_i.
  - rs1_zero_i=1, rd_zero_i=0: AVL = VLMAX.
  - rs1_zero_i=1, rd_zero_i=1: AVL = current vl.
- New vl = (AVL <= VLMAX) ? AVL : VLMAX; 32-bit unsigned compare. Result = new vl (rd write handled by CPU; rd_zero_i does not suppress valid).
- CSR read: vl, vtype, or VLEN/8. No state change.
- vl and vtype registers load the new values only on the RESP-state cycle with VCFG_commit_i=1 and flush_i=0. vl_o/vtype_o show the new values from the next cycle.

## Timing
- Reset values:
  - state IDLE, cfg_ready_o=1;
  - VCFG_read_valid_o=0, VCFG_read_data_o=0;
  - vl_o=0, vtype_o=0x8000_0000.
- Latency: accept at cycle N; CALC at N+1; VCFG_read_valid_o=1 at N+2.
- Minimum op-to-op spacing is 3 cycles (accept, CALC, RESP), with a new accept possible the cycle after commit.
- VCFG_read_valid_o and VCFG_read_data_o are registered.
  - They hold stable in RESP until commit or flush.
  - They drop the cycle after commit.
- VCFG_commit_i outside RESP is ignored.
- Commit and flush in the same cycle: flush wins; no update.
- Reset asserted mid-operation returns everything to reset values immediately; no partial CSR update.

## Test plan
- Reset release -> vl_o=0, vtype_o=0x8000_0000, cfg_ready_o=1, valid=0.
- vsetvli with avl_i=10, vtype_i=0x10 (e32,m1), VLEN=128 -> valid at cycle+2 with data 4; with commit, vl_o=4 and vtype_o=0x10 next cycle.
- vsetvli with rs1_zero_i=1, rd_zero_i=0, vtype_i=0x09 (e16,m2) -> data 16; then vsetivli avl_i=100, vtype_i=0x03 (e8,m8) -> data 100.
- vsetvl with vtype_i=0x15 (e32,mf8) -> data 0, vtype_o=0x8000_0000, vl_o=0; next CSR read of vlenb -> 16, vl/vtype unchanged.
- Hold VCFG_commit_i=0 for 3 cycles in RESP:
  - valid and data stay stable, cfg_ready_o=0, vl_o unchanged;
  - then commit -> update; new op accepted the next cycle.
- flush_i in CALC -> no valid, vl_o unchanged.
- flush_i with commit in RESP -> no update, back to IDLE.
- Reset asserted in RESP -> valid=0 and reset values immediately.
